tomasulo_issue_ctrl: RTL
========================

Name: tomasulo_issue_ctrl

Overview:
Issue-stage scheduler for the Tomasulo core. It sits between the instruction decoder and the three reservation-station (RS) groups: ALU, MUL and MEM. It accepts one decoded instruction per cycle over a valid/ready handshake and allocates a free RS slot in the target class. It renames the destination through a 32-entry register status table (RAT) and emits a registered dispatch packet carrying the source tags. CDB broadcasts free RS slots and clear RAT entries.

Parameters:
N_ALU, 4, ALU RS slots (1..4)
N_MUL, 2, MUL RS slots (1..4)
N_MEM, 4, MEM RS slots (1..4)
TAG_W, 4, tag width = 2-bit class + 2-bit slot index

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
flush  in  1  discard all renames and RS allocations
in_valid  in  1  decoded instruction present
in_ready  out  1  instruction accepted this cycle
in_mem  in  1  decoder mem flag
in_mul  in  1  decoder mul flag
in_lwsw  in  1  1=load, 0=store (valid when in_mem)
in_inactive  in  1  decoder inactive flag
in_rs1, in_rs2, in_rd  in  5 each  register fields
cdb_valid  in  1  result broadcast
cdb_tag  in  TAG_W  producing RS tag
dis_valid  out  1  dispatch packet valid (one-cycle pulse)
dis_class  out  2  01 ALU, 10 MUL, 11 MEM
dis_tag  out  TAG_W  allocated RS tag
dis_lwsw  out  1  load/store flag
dis_q1, dis_q2  out  TAG_W  source producer tags, 0 = value in register file
dis_rs1, dis_rs2, dis_rd  out  5 each  passthrough register fields
busy_alu, busy_mul, busy_mem  out  3 each  allocated slot counts

Behaviour:
- Tag encoding: {class[1:0], slot[1:0]}. Tag 0 is reserved and means "ready".
- Class select:
  - in_mem → MEM
  - else in_mul → MUL
  - else ALU
- Reset (rst_n=0 at posedge):
  - All RAT entries cleared to 0.
  - All free masks set to all-ones over the valid slots.
  - dis_valid=0, all dis_* fields 0, busy_* = 0.
  - in_ready is forced 0 during the reset cycle.
- in_ready (combinational):
  - 1 if in_inactive=1 (the instruction is consumed and dropped, no dispatch).
  - Otherwise 1 if the target class has at least one free slot in the registered mask.
  - Otherwise 0.
  - Forced 0 while flush=1.
- Accept: in_valid & in_ready & ~in_inactive.
  - Allocate the lowest-index free slot of the class.
  - Next cycle: dis_valid=1 with the packet; latency is 1 cycle.
  - dis_q1 = RAT[in_rs1] and dis_q2 = RAT[in_rs2], each after bypass.
  - Register 0 always reads tag 0.
- Rename: on accept, RAT[in_rd] ← allocated tag, except:
  - stores (in_mem & ~in_lwsw),
  - in_rd = 0.
- CDB, on cdb_valid:
  - Free the slot named by cdb_tag.
  - Clear every RAT entry equal to cdb_tag.
  - A cdb_tag with class 00, or a slot already free, is ignored.
- Simultaneous events:
  - CDB tag equals a source lookup in the same cycle → that dis_q is 0 (bypass).
  - CDB clears RAT[x] while an accept renames x in the same cycle → the new tag wins.
  - Release and allocate in the same class in the same cycle → the freed slot is usable only from the next cycle. in_ready uses the pre-update mask; a slot is never double-allocated.
  - Store with rs1 = rs2 → both dis_q fields carry the same tag.
- flush:
  - On the next edge, RAT cleared, all slots freed, dis_valid=0.
  - A coincident CDB is ignored.
  - flush has priority over accept.
- busy_* = popcount of the allocated slots, updated with the masks.
- dis_valid is 0 in every cycle that follows a non-accept.

Decomposition:
- Shared package tomasulo_pkg holds:
  - class enum (CLS_NONE/ALU/MUL/MEM),
  - TAG_W, tag_t, reg_idx_t,
  - dispatch packet struct.
- One sub-module, rs_slot_alloc, instantiated once per class, contains:
  - free mask,
  - lowest-free priority encoder,
  - release-by-slot logic,
  - popcount.

Test Plan:
- Reset, then ALU add (rd=5, rs1=1, rs2=2) → next cycle dis_valid=1, dis_tag=4'b0100, q1=q2=0. RAT[5]=0100.
- Five back-to-back ALU ops with N_ALU=4 → tags 0100,0101,0110,0111, then in_ready=0. CDB tag 0101 → in_ready=1 the next cycle and the fifth op gets tag 0101.
- MUL rd=3, then ALU with rs1=3 → q1=1000. Repeat with cdb_tag=1000 in the same cycle as the ALU accept → q1=0.
- Store (mem=1, lwsw=0, rd field=7) → MEM tag 1100, RAT[7] unchanged. Load rd=0 → no rename.
- CDB clears RAT[9] in the same cycle a new op renames r9 → RAT[9] equals the new tag. Inactive instruction → in_ready=1, no dis_valid.
- Fill all classes, assert flush with a coincident cdb_valid → busy_* = 0 and RAT cleared. rst_n=0 mid-stream → all outputs 0 the next cycle.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared types for the Tomasulo issue stage: class encoding, tags and the dispatch packet.
package tomasulo_pkg;

  localparam int unsigned TAG_W     = 4;
  localparam int unsigned SLOT_W    = 2;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned N_REGS    = 32;
  localparam int unsigned MAX_SLOTS = 4;
  localparam int unsigned CNT_W     = 3;

  typedef enum logic [1:0] {
    CLS_NONE = 2'b00,
    CLS_ALU  = 2'b01,
    CLS_MUL  = 2'b10,
    CLS_MEM  = 2'b11
  } cls_e;

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [SLOT_W-1:0] slot_t;

  typedef struct packed {
    logic     valid;
    cls_e     cls;
    tag_t     tag;
    logic     lwsw;
    tag_t     q1;
    tag_t     q2;
    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t rd;
  } dis_pkt_t;

  // Tag 0 (class NONE) is reserved as "operand ready".
  function automatic tag_t make_tag(cls_e cls, slot_t slot);
    return {cls, slot};
  endfunction

endpackage

// File: rtl/rs_slot_alloc.sv
// Free-slot tracker for one reservation-station class: lowest-free pick, release, occupancy count.
module rs_slot_alloc
  import tomasulo_pkg::*;
#(
  parameter int unsigned N_SLOTS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             alloc_i,
  input  logic             rel_i,
  input  slot_t            rel_slot_i,
  output logic             any_free_o,
  output slot_t            alloc_slot_o,
  output logic [CNT_W-1:0] busy_o
);

  localparam logic [MAX_SLOTS-1:0] VALID_MASK = MAX_SLOTS'((1 << N_SLOTS) - 1);

  logic [MAX_SLOTS-1:0] free_q, free_d;
  logic [CNT_W-1:0]     busy_q, busy_d;

  assign any_free_o = |free_q;
  assign busy_o     = busy_q;

  // Lowest-index free slot wins.
  always_comb begin
    alloc_slot_o = '0;
    for (int i = MAX_SLOTS - 1; i >= 0; i--) begin
      if (free_q[i]) alloc_slot_o = slot_t'(i);
    end
  end

  // Releases of nonexistent or already-free slots are dropped.
  always_comb begin
    free_d = free_q;
    if (alloc_i) free_d[alloc_slot_o] = 1'b0;
    if (rel_i && VALID_MASK[rel_slot_i] && !free_q[rel_slot_i]) free_d[rel_slot_i] = 1'b1;
    if (clr_i) free_d = VALID_MASK;
    busy_d = '0;
    for (int i = 0; i < MAX_SLOTS; i++) begin
      busy_d = busy_d + CNT_W'(VALID_MASK[i] & ~free_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      free_q <= VALID_MASK;
      busy_q <= '0;
    end else begin
      free_q <= free_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/tomasulo_issue_ctrl.sv
// Issue-stage scheduler: allocates RS slots per class, renames through the RAT,
// and emits a registered dispatch packet with CDB bypass on source lookups.
module tomasulo_issue_ctrl
  import tomasulo_pkg::*;
#(
  parameter int unsigned N_ALU = 4,
  parameter int unsigned N_MUL = 2,
  parameter int unsigned N_MEM = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mem,
  input  logic             in_mul,
  input  logic             in_lwsw,
  input  logic             in_inactive,
  input  logic [REG_W-1:0] in_rs1,
  input  logic [REG_W-1:0] in_rs2,
  input  logic [REG_W-1:0] in_rd,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  output logic             dis_valid,
  output logic [1:0]       dis_class,
  output logic [TAG_W-1:0] dis_tag,
  output logic             dis_lwsw,
  output logic [TAG_W-1:0] dis_q1,
  output logic [TAG_W-1:0] dis_q2,
  output logic [REG_W-1:0] dis_rs1,
  output logic [REG_W-1:0] dis_rs2,
  output logic [REG_W-1:0] dis_rd,
  output logic [CNT_W-1:0] busy_alu,
  output logic [CNT_W-1:0] busy_mul,
  output logic [CNT_W-1:0] busy_mem
);

  tag_t     rat_q [N_REGS];
  tag_t     rat_d [N_REGS];
  dis_pkt_t pkt_q, pkt_d;

  cls_e  in_cls, cdb_cls;
  logic  free_alu, free_mul, free_mem, cls_has_free;
  slot_t slot_alu, slot_mul, slot_mem, alloc_slot;
  tag_t  alloc_tag, q1, q2;
  logic  accept, rename, cdb_live;

  always_comb begin
    in_cls       = CLS_ALU;
    alloc_slot   = slot_alu;
    cls_has_free = free_alu;
    if (in_mem) begin
      in_cls       = CLS_MEM;
      alloc_slot   = slot_mem;
      cls_has_free = free_mem;
    end else if (in_mul) begin
      in_cls       = CLS_MUL;
      alloc_slot   = slot_mul;
      cls_has_free = free_mul;
    end
  end

  assign in_ready  = rst_n & ~flush & (in_inactive | cls_has_free);
  assign accept    = in_valid & in_ready & ~in_inactive;
  assign rename    = ~(in_mem & ~in_lwsw) & (in_rd != '0);
  assign alloc_tag = make_tag(in_cls, alloc_slot);
  assign cdb_cls   = cls_e'(cdb_tag[TAG_W-1:SLOT_W]);
  assign cdb_live  = cdb_valid & ~flush & (cdb_cls != CLS_NONE);

  // Source lookup with same-cycle CDB bypass; r0 is always ready.
  always_comb begin
    q1 = rat_q[in_rs1];
    q2 = rat_q[in_rs2];
    if (in_rs1 == '0 || (cdb_live && q1 == cdb_tag)) q1 = '0;
    if (in_rs2 == '0 || (cdb_live && q2 == cdb_tag)) q2 = '0;
  end

  // CDB clears first so a same-cycle rename of the same register wins.
  always_comb begin
    rat_d = rat_q;
    if (flush) begin
      for (int i = 0; i < N_REGS; i++) rat_d[i] = '0;
    end else begin
      if (cdb_live) begin
        for (int i = 0; i < N_REGS; i++) begin
          if (rat_q[i] == cdb_tag) rat_d[i] = '0;
        end
      end
      if (accept && rename) rat_d[in_rd] = alloc_tag;
    end
  end

  always_comb begin
    pkt_d = '0;
    if (accept) begin
      pkt_d.valid = 1'b1;
      pkt_d.cls   = in_cls;
      pkt_d.tag   = alloc_tag;
      pkt_d.lwsw  = in_lwsw;
      pkt_d.q1    = q1;
      pkt_d.q2    = q2;
      pkt_d.rs1   = in_rs1;
      pkt_d.rs2   = in_rs2;
      pkt_d.rd    = in_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REGS; i++) rat_q[i] <= '0;
      pkt_q <= '0;
    end else begin
      for (int i = 0; i < N_REGS; i++) rat_q[i] <= rat_d[i];
      pkt_q <= pkt_d;
    end
  end

  rs_slot_alloc #(.N_SLOTS(N_ALU)) u_alu (
    .clk(clk), .rst_n(rst_n), .clr_i(flush),
    .alloc_i(accept && in_cls == CLS_ALU),
    .rel_i(cdb_live && cdb_cls == CLS_ALU), .rel_slot_i(slot_t'(cdb_tag[SLOT_W-1:0])),
    .any_free_o(free_alu), .alloc_slot_o(slot_alu), .busy_o(busy_alu)
  );

  rs_slot_alloc #(.N_SLOTS(N_MUL)) u_mul (
    .clk(clk), .rst_n(rst_n), .clr_i(flush),
    .alloc_i(accept && in_cls == CLS_MUL),
    .rel_i(cdb_live && cdb_cls == CLS_MUL), .rel_slot_i(slot_t'(cdb_tag[SLOT_W-1:0])),
    .any_free_o(free_mul), .alloc_slot_o(slot_mul), .busy_o(busy_mul)
  );

  rs_slot_alloc #(.N_SLOTS(N_MEM)) u_mem (
    .clk(clk), .rst_n(rst_n), .clr_i(flush),
    .alloc_i(accept && in_cls == CLS_MEM),
    .rel_i(cdb_live && cdb_cls == CLS_MEM), .rel_slot_i(slot_t'(cdb_tag[SLOT_W-1:0])),
    .any_free_o(free_mem), .alloc_slot_o(slot_mem), .busy_o(busy_mem)
  );

  assign dis_valid = pkt_q.valid;
  assign dis_class = pkt_q.cls;
  assign dis_tag   = pkt_q.tag;
  assign dis_lwsw  = pkt_q.lwsw;
  assign dis_q1    = pkt_q.q1;
  assign dis_q2    = pkt_q.q2;
  assign dis_rs1   = pkt_q.rs1;
  assign dis_rs2   = pkt_q.rs2;
  assign dis_rd    = pkt_q.rd;

endmodule
